hall_call_queue: RTL and testbench
==================================

// Module: hall_call_queue
// PURPOSE
// Request side of the elevator dispatcher handshake. Latches hall-button presses into a per-floor
// pending mask and selects one pending floor at a time, round-robin. That floor is presented as a
// one-hot requested_floor, and its pending bit is retired when the dispatcher raises request_taken.
// Sits between the hall-button panel and the two-car dispatcher, and also drives the hall-lamp mask.
// PARAMETERS
// NUM_FLOORS      64   floor count; width of one-hot floor vectors (2..64)
// TIMEOUT_CYCLES  255  cycles a request is presented untaken before the arbiter rotates (>=1)
// PORTS
// clk              in   1           rising-edge clock
// reset_n          in   1           asynchronous active-low reset
// hall_button      in   NUM_FLOORS  level, bit i = floor i call pressed (one cycle or longer)
// clear_all        in   1           sync: drop all pending calls, return to IDLE
// request_taken    in   1           dispatcher accepted current request (level; later drops to 0)
// requested_floor  out  NUM_FLOORS  one-hot floor being offered; all-zero when req_valid=0
// req_valid        out  1           requested_floor holds a live request
// pending_floors   out  NUM_FLOORS  pending-call mask (hall lamps), includes presented floor
// pending_count    out  7           popcount of pending_floors (0..64)
// timeout_pulse    out  1           1-cycle pulse when a request rotates on timeout
// BEHAVIOUR
// Reset: all outputs 0, state=IDLE, rr_ptr=0, timer=0; applies immediately, any state.
// Pending update, every cycle: pending <= (pending | hall_button) & ~retire_mask.
// retire_mask = requested_floor on the accept cycle, else 0.
// Retire wins over a same-cycle press of the same floor, so no double service.
// Arbiter: first pending bit at index >= rr_ptr, wrapping past NUM_FLOORS-1 to 0.
// The arbiter is combinational; the winner is registered into requested_floor on the IDLE->PRESENT cycle.
// FSM states: IDLE, PRESENT, WAIT_DROP.
//  IDLE: req_valid=0, requested_floor=0.
//    If pending!=0 and request_taken==0, load the winner, req_valid<=1, timer<=0, go PRESENT.
//    Latency: press in cycle N -> req_valid=1 in cycle N+2 (pending reg, then grant reg).
//  PRESENT: hold requested_floor stable; timer increments each cycle.
//    request_taken==1: retire the floor, rr_ptr <= granted index+1 (mod NUM_FLOORS), req_valid<=0,
//      requested_floor<=0, go WAIT_DROP.
//    Else if timer==TIMEOUT_CYCLES-1: rr_ptr <= granted index+1, floor stays pending,
//      timeout_pulse=1, req_valid<=0, go IDLE.
//      With one pending floor it is re-presented 1 cycle later.
//  WAIT_DROP: req_valid=0; wait for request_taken==0, then go IDLE.
//    No new request is offered while request_taken is high, so the dispatcher never sees two accepts.
// clear_all: pending<=0, req_valid<=0, requested_floor<=0, timer<=0, go IDLE; rr_ptr kept.
//   A hall_button in the same cycle is dropped.
// request_taken high while in IDLE (a stale accept from the other source) blocks the grant until it drops.
// pending_count, pending_floors: registered, consistent with pending in the same cycle.
// Invariants: requested_floor is one-hot iff req_valid, else 0. The presented floor is always pending.
// TESTING
// 1 Reset: hold reset_n=0 mid-PRESENT -> all outputs 0 same cycle; release -> IDLE, count=0.
// 2 Press floor 5 (bit5) at cycle 0, taken=0 -> cycle 2: req_valid=1, requested_floor=1<<5;
//   assert taken at cycle 4 -> cycle 5: pending bit5=0, req_valid=0; drop taken -> IDLE, count=0.
// 3 Press floors 2, 9, 40 together, rr_ptr=0 -> served in order 2, 9, 40 via three handshakes;
//   then press 3 -> served as 3 after wrap, since rr_ptr=41.
// 4 Timeout, TIMEOUT_CYCLES=4: pending {7,12}, never take -> 7 is offered 4 cycles, then timeout_pulse,
//   then 12 offered; bit 7 still pending; count stays 2.
// 5 Same-cycle hazard: floor 7 presented, taken=1 and hall_button bit7=1 in the same cycle
//   -> bit7 cleared, count decrements, floor 7 not re-offered.
// 6 clear_all in PRESENT with pending {1,63} -> next cycle pending=0, req_valid=0, IDLE;
//   a press in the same cycle is not latched.

Source files
------------

// File: rtl/hall_call_queue.sv
// Hall-call request queue: latches hall-button presses into a pending mask and offers one
// pending floor at a time to the dispatcher, round-robin, with a rotate-on-timeout arbiter.
module hall_call_queue #(
  parameter int unsigned NUM_FLOORS     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] hall_button,
  input  logic                  clear_all,
  input  logic                  request_taken,
  output logic [NUM_FLOORS-1:0] requested_floor,
  output logic                  req_valid,
  output logic [NUM_FLOORS-1:0] pending_floors,
  output logic [6:0]            pending_count,
  output logic                  timeout_pulse
);

  localparam int unsigned IDX_W = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESENT   = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t                state, state_d;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]      grant_idx, grant_idx_d;
  logic [IDX_W-1:0]      next_ptr;
  logic [TMR_W-1:0]      timer, timer_d;
  logic [NUM_FLOORS-1:0] pending_d;
  logic [NUM_FLOORS-1:0] req_floor_d;
  logic [NUM_FLOORS-1:0] retire_mask;
  logic                  req_valid_d;
  logic                  pulse_d;
  logic [CNT_W-1:0]      count_d;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  int unsigned           cand;

  // Round-robin search: first pending floor at or above rr_ptr, wrapping to floor 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_FLOORS; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_FLOORS) cand = cand - NUM_FLOORS;
      if (!win_found && pending_floors[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign next_ptr = (grant_idx == IDX_W'(NUM_FLOORS - 1)) ? '0 : grant_idx + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    grant_idx_d = grant_idx;
    timer_d     = timer;
    req_floor_d = requested_floor;
    req_valid_d = req_valid;
    pulse_d     = 1'b0;
    retire_mask = '0;
    pending_d   = pending_floors;

    if (clear_all) begin
      pending_d   = '0;
      req_valid_d = 1'b0;
      req_floor_d = '0;
      timer_d     = '0;
      state_d     = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (win_found && !request_taken) begin
            req_floor_d          = '0;
            req_floor_d[win_idx] = 1'b1;
            grant_idx_d          = win_idx;
            req_valid_d          = 1'b1;
            timer_d              = '0;
            state_d              = PRESENT;
          end
        end
        PRESENT: begin
          timer_d = timer + TMR_W'(1);
          if (request_taken) begin
            retire_mask = requested_floor;
            rr_ptr_d    = next_ptr;
            req_valid_d = 1'b0;
            req_floor_d = '0;
            state_d     = WAIT_DROP;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            rr_ptr_d    = next_ptr;
            pulse_d     = 1'b1;
            req_valid_d = 1'b0;
            req_floor_d = '0;
            timer_d     = '0;
            state_d     = IDLE;
          end
        end
        WAIT_DROP: begin
          if (!request_taken) state_d = IDLE;
        end
        default: begin
          req_valid_d = 1'b0;
          req_floor_d = '0;
          state_d     = IDLE;
        end
      endcase
      // Retire beats a same-cycle press of the floor being accepted.
      pending_d = (pending_floors | hall_button) & ~retire_mask;
    end
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      count_d = count_d + CNT_W'(pending_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_idx       <= '0;
      timer           <= '0;
      requested_floor <= '0;
      req_valid       <= 1'b0;
      pending_floors  <= '0;
      pending_count   <= '0;
      timeout_pulse   <= 1'b0;
    end else begin
      state           <= state_d;
      rr_ptr          <= rr_ptr_d;
      grant_idx       <= grant_idx_d;
      timer           <= timer_d;
      requested_floor <= req_floor_d;
      req_valid       <= req_valid_d;
      pending_floors  <= pending_d;
      pending_count   <= count_d;
      timeout_pulse   <= pulse_d;
    end
  end

endmodule

// File: tb/tb_hall_call_queue.sv
// Bench for hall_call_queue: directed vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural queue model.
module tb_hall_call_queue;

  localparam int unsigned NF = 64;
  localparam int unsigned TO = 4;

  logic          clk;
  logic          reset_n;
  logic [NF-1:0] hall_button;
  logic          clear_all;
  logic          request_taken;
  logic [NF-1:0] requested_floor;
  logic          req_valid;
  logic [NF-1:0] pending_floors;
  logic [6:0]    pending_count;
  logic          timeout_pulse;

  hall_call_queue #(.NUM_FLOORS(NF), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .hall_button     (hall_button),
    .clear_all       (clear_all),
    .request_taken   (request_taken),
    .requested_floor (requested_floor),
    .req_valid       (req_valid),
    .pending_floors  (pending_floors),
    .pending_count   (pending_count),
    .timeout_pulse   (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Behavioural model: pending set, floor on offer (-1 none), waiting for accept to drop,
  // cycles the current offer has been shown, round-robin start floor.
  logic [NF-1:0] m_pend;
  int            m_off;
  bit            m_wdrop;
  int            m_age;
  int            m_ptr;
  bit            m_pulse;

  typedef struct {
    bit            pre_rst;
    logic [NF-1:0] hb;
    bit            tk;
    bit            exp_v;
    int            exp_f;
    int            exp_c;
    bit            exp_p;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [NF-1:0] fb(input int f);
    logic [NF-1:0] v;
    v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  function automatic int first_from(input logic [NF-1:0] p, input int start);
    for (int k = 0; k < NF; k++) begin
      if (p[(start + k) % NF]) return (start + k) % NF;
    end
    return -1;
  endfunction

  function automatic void add(input bit r, input logic [NF-1:0] hb, input bit tk,
                              input bit v, input int f, input int c, input bit p);
    vec_t e;
    e.pre_rst = r; e.hb = hb; e.tk = tk;
    e.exp_v = v; e.exp_f = f; e.exp_c = c; e.exp_p = p;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_off = -1; m_wdrop = 0; m_age = 0; m_ptr = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic [NF-1:0] hb, input bit clr, input bit tk);
    logic [NF-1:0] ret;
    ret = '0;
    m_pulse = 0;
    if (clr) begin
      m_pend = '0; m_off = -1; m_wdrop = 0; m_age = 0;
    end else begin
      if (m_wdrop) begin
        if (!tk) m_wdrop = 0;
      end else if (m_off >= 0) begin
        if (tk) begin
          ret[m_off] = 1'b1; m_ptr = (m_off + 1) % NF; m_off = -1; m_wdrop = 1;
        end else if (m_age == TO - 1) begin
          m_ptr = (m_off + 1) % NF; m_off = -1; m_pulse = 1; m_age = 0;
        end else begin
          m_age++;
        end
      end else if (m_pend != '0 && !tk) begin
        m_off = first_from(m_pend, m_ptr); m_age = 0;
      end
      m_pend = (m_pend | hb) & ~ret;
    end
  endtask

  task automatic check_model();
    logic [NF-1:0] ef;
    ef = (m_off >= 0) ? fb(m_off) : '0;
    chk("req_valid", 64'(req_valid), 64'(m_off >= 0));
    chk("requested_floor", 64'(requested_floor), 64'(ef));
    chk("pending_floors", 64'(pending_floors), 64'(m_pend));
    chk("pending_count", 64'(pending_count), 64'($countones(m_pend)));
    chk("timeout_pulse", 64'(timeout_pulse), 64'(m_pulse));
  endtask

  task automatic cycle(input logic [NF-1:0] hb, input bit clr, input bit tk);
    hall_button = hb; clear_all = clr; request_taken = tk;
    @(posedge clk);
    model_step(hb, clr, tk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    hall_button = '0; clear_all = 1'b0; request_taken = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_model();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0;
    do_reset();

    // Single call: press floor 5, accept, drop accept.
    add(0, fb(5), 0, 0, -1, 1, 0);
    add(0, '0,    0, 1,  5, 1, 0);
    add(0, '0,    0, 1,  5, 1, 0);
    add(0, '0,    1, 0, -1, 0, 0);
    add(0, '0,    1, 0, -1, 0, 0);
    add(0, '0,    0, 0, -1, 0, 0);
    // Round robin over 2, 9, 40 then wrap to 3.
    add(1, fb(2) | fb(9) | fb(40), 0, 0, -1, 3, 0);
    add(0, '0,    0, 1,  2, 3, 0);
    add(0, '0,    1, 0, -1, 2, 0);
    add(0, '0,    0, 0, -1, 2, 0);
    add(0, '0,    0, 1,  9, 2, 0);
    add(0, '0,    1, 0, -1, 1, 0);
    add(0, '0,    0, 0, -1, 1, 0);
    add(0, '0,    0, 1, 40, 1, 0);
    add(0, '0,    1, 0, -1, 0, 0);
    add(0, fb(3), 0, 0, -1, 1, 0);
    add(0, '0,    0, 1,  3, 1, 0);
    add(0, '0,    1, 0, -1, 0, 0);
    add(0, '0,    0, 0, -1, 0, 0);
    // Timeout rotation with {7,12} never taken for 4 cycles.
    add(0, fb(7) | fb(12), 0, 0, -1, 2, 0);
    add(0, '0,    0, 1,  7, 2, 0);
    add(0, '0,    0, 1,  7, 2, 0);
    add(0, '0,    0, 1,  7, 2, 0);
    add(0, '0,    0, 1,  7, 2, 0);
    add(0, '0,    0, 0, -1, 2, 1);
    add(0, '0,    0, 1, 12, 2, 0);
    add(0, '0,    1, 0, -1, 1, 0);
    add(0, '0,    0, 0, -1, 1, 0);
    add(0, '0,    0, 1,  7, 1, 0);
    // Accept and re-press of floor 7 in the same cycle.
    add(0, fb(7), 1, 0, -1, 0, 0);
    add(0, '0,    0, 0, -1, 0, 0);
    add(0, '0,    0, 0, -1, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      cycle(tbl[i].hb, 1'b0, tbl[i].tk);
      chk($sformatf("tbl%0d_valid", i), 64'(req_valid), 64'(tbl[i].exp_v));
      chk($sformatf("tbl%0d_floor", i), 64'(requested_floor),
          64'((tbl[i].exp_f >= 0) ? fb(tbl[i].exp_f) : '0));
      chk($sformatf("tbl%0d_count", i), 64'(pending_count), 64'(tbl[i].exp_c));
      chk($sformatf("tbl%0d_pulse", i), 64'(timeout_pulse), 64'(tbl[i].exp_p));
    end

    // clear_all while presenting, with a same-cycle press that must be dropped.
    cycle(fb(1) | fb(63), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    chk("clr_pre_floor", 64'(requested_floor), 64'(fb(63)));
    cycle(fb(20), 1'b1, 1'b0);
    chk("clr_pending", 64'(pending_floors), 64'd0);
    chk("clr_valid", 64'(req_valid), 64'd0);
    cycle('0, 1'b0, 1'b0);
    chk("clr_after_valid", 64'(req_valid), 64'd0);
    chk("clr_after_count", 64'(pending_count), 64'd0);

    // Asynchronous reset while presenting.
    cycle(fb(10), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    chk("rst_pre_valid", 64'(req_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_floor", 64'(requested_floor), 64'd0);
    chk("rst_pending", 64'(pending_floors), 64'd0);
    chk("rst_count", 64'(pending_count), 64'd0);
    chk("rst_pulse", 64'(timeout_pulse), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle('0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [NF-1:0] hb;
      hb = '0;
      if ($urandom_range(0, 3) == 0) hb[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 15) == 0) hb = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      cycle(hb, $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
